multi_cycle_ctrl: RTL and testbench
===================================

Name: multi_cycle_ctrl

Overview:
Multi-cycle sequencer for the 32-bit datapath. Replaces single-cycle opcode decode with a Moore/Mealy FSM that steps each instruction through fetch, decode, execute, memory and writeback, sharing one ALU and one unified memory port. Memory accesses use a `mem_ready` handshake with a wait-state timeout. A retired-instruction counter is included.

Parameters:
TIMEOUT, 15, maximum wait cycles on `mem_ready` before trap; 0 disables the timeout.
CNT_W, 32, width of `instr_cnt`.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  6  instr[31:26] from the instruction register
alu_zero  in  1  ALU zero flag
mem_ready  in  1  memory has completed the current read or write this cycle
pc_en  out  1  PC load enable: pc_wrt | (pc_wrt_cond & alu_zero)
pc_src  out  2  00 ALU result, 01 ALUOut register, 10 jump target
i_or_d  out  1  memory address select: 0 PC, 1 ALUOut
mem_rd  out  1  memory read request
mem_wrt  out  1  memory write request
ir_wrt  out  1  instruction register load
reg_dst  out  1  destination register select: 1 rd, 0 rt
mem_to_reg  out  1  register writeback source: 1 MDR, 0 ALUOut
reg_wrt  out  1  register file write enable
alu_src_a  out  1  ALU A input: 0 PC, 1 reg A
alu_src_b  out  2  ALU B input: 00 reg B, 01 constant 4, 10 sign-extended imm, 11 imm<<2
alu_op  out  3  ALU opcode: 000 add, 001 sub, 010 funct, 011 addi, 100 andi, 101 xori, 110 slti
trap  out  1  sticky fault flag (illegal opcode or memory timeout)
state  out  4  current FSM state (debug)
instr_cnt  out  CNT_W  retired-instruction count

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, EXEC_R=7, R_WB=8, EXEC_I=9, I_WB=10, BRANCH=11, JUMP=12, TRAP=13.
- Reset (asynchronous, any time, including mid-instruction):
  - state=IDLE, instr_cnt=0, wait_cnt=0.
  - IDLE drives every output 0 (all 2/3-bit fields 00/000).
  - IDLE goes to FETCH on the first clock edge after rst is low.
- All outputs not listed for a state are 0.
- FETCH: mem_rd=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=00.
  - ir_wrt=mem_ready and pc_wrt=mem_ready (Mealy on mem_ready).
  - Goes to DECODE when mem_ready=1, otherwise stays.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (precompute the branch target). Next state by opcode:
  - 000000 (rtype) or 010111 (slt) -> EXEC_R
  - 010000/010001/010010/011000 (addi/andi/xori/slti) -> EXEC_I
  - 010101 (lw) or 010110 (sw) -> MEM_ADDR
  - 010011 (beq) -> BRANCH
  - 110000 (jmp) -> JUMP
  - any other opcode -> TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: i_or_d=1, mem_rd=1. Goes to MEM_WB on mem_ready.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_wrt=1. Goes to FETCH.
- MEM_WR: i_or_d=1, mem_wrt=1. Goes to FETCH on mem_ready.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=010. Goes to R_WB.
- R_WB: reg_dst=1, mem_to_reg=0, reg_wrt=1. Goes to FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10. alu_op is 011/100/101/110 for addi/andi/xori/slti. Goes to I_WB.
- I_WB: reg_dst=0, mem_to_reg=0, reg_wrt=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_wrt_cond=1, pc_src=01. Goes to FETCH.
- JUMP: pc_wrt=1, pc_src=10. Goes to FETCH.
- TRAP: all outputs 0 except trap=1. Terminal; only rst exits.
- Latency with mem_ready held high:
  - beq, jmp: 3 cycles
  - R-type, I-type, sw: 4 cycles
  - lw: 5 cycles
- Wait timeout:
  - wait_cnt clears on every state change.
  - wait_cnt increments each cycle in FETCH, MEM_RD or MEM_WR while mem_ready=0.
  - If mem_ready=0 and wait_cnt==TIMEOUT-1, the next state is TRAP.
  - mem_ready arriving on that same cycle wins: normal transition, no trap.
- instr_cnt increments by 1 on each transition into FETCH from MEM_WB, MEM_WR, R_WB, I_WB, BRANCH or JUMP. It wraps modulo 2^CNT_W.
- The IDLE->FETCH transition does not count. TRAP never counts.
- pc_en is combinational from state, alu_zero and mem_ready. No other output depends on alu_zero.

Test Plan:
- Reset behaviour: assert rst mid-EXEC_R, with mem_ready=1 -> all outputs 0 and state=0 immediately (asynchronous). After release: state 1 one cycle later, instr_cnt=0.
- R-type, mem_ready=1: opcode=000000 -> states 1,2,7,8,1. reg_wrt=1 and reg_dst=1 only in state 8. instr_cnt 0->1.
- lw with 2 wait states: mem_ready low for 2 cycles in MEM_RD -> MEM_RD lasts 3 cycles, then MEM_WB with mem_to_reg=1, reg_wrt=1. The whole instruction takes 7 cycles.
- beq: alu_zero=1 -> pc_en=1, pc_src=01 in BRANCH. Repeat with alu_zero=0 -> pc_en=0. instr_cnt increments both times.
- Illegal opcode 111111 -> DECODE then TRAP. trap=1, reg_wrt=mem_wrt=pc_en=0, held for 20 cycles. instr_cnt unchanged.
- Timeout with TIMEOUT=4: mem_ready=0 in FETCH -> TRAP entered on the 5th cycle. Separately, mem_ready=1 on the 4th waiting cycle -> DECODE, no trap.

Source files
------------

// File: rtl/multi_cycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl_if
// Bundle between the multi-cycle sequencer and the 32-bit datapath.
//   opcode     : instr[31:26] from the instruction register   (datapath -> ctrl)
//   alu_zero   : ALU zero flag                                 (datapath -> ctrl)
//   mem_ready  : unified memory port completed this cycle      (datapath -> ctrl)
//   pc_en, pc_src, i_or_d, mem_rd, mem_wrt, ir_wrt, reg_dst,
//   mem_to_reg, reg_wrt, alu_src_a, alu_src_b, alu_op         (ctrl -> datapath)
//   trap, state, instr_cnt : status / debug                    (ctrl -> datapath)
// The controller is the master; the datapath (or a bench) is the slave.
// ---------------------------------------------------------------------------
interface multi_cycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             alu_zero;
  logic             mem_ready;

  logic             pc_en;
  logic [1:0]       pc_src;
  logic             i_or_d;
  logic             mem_rd;
  logic             mem_wrt;
  logic             ir_wrt;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_wrt;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_op;
  logic             trap;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  opcode, alu_zero, mem_ready,
    output pc_en, pc_src, i_or_d, mem_rd, mem_wrt, ir_wrt, reg_dst,
           mem_to_reg, reg_wrt, alu_src_a, alu_src_b, alu_op,
           trap, state, instr_cnt
  );

  modport slave (
    output opcode, alu_zero, mem_ready,
    input  pc_en, pc_src, i_or_d, mem_rd, mem_wrt, ir_wrt, reg_dst,
           mem_to_reg, reg_wrt, alu_src_a, alu_src_b, alu_op,
           trap, state, instr_cnt
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl
// Multi-cycle sequencer: steps each instruction through fetch, decode,
// execute, memory and writeback sharing one ALU and one memory port.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous, active-high reset
//   bus  : multi_cycle_ctrl_if.master (datapath inputs, control outputs,
//          trap / state / retired-instruction count)
// Parameters:
//   TIMEOUT : max wait cycles on mem_ready before trapping (0 = never)
//   CNT_W   : width of instr_cnt
// ---------------------------------------------------------------------------
module multi_cycle_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_cycle_ctrl_if.master    bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_WB     = 4'd8,
    S_EXEC_I   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_SLT   = 6'b010111;
  localparam logic [5:0] OP_ADDI  = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_XORI  = 6'b010010;
  localparam logic [5:0] OP_SLTI  = 6'b011000;
  localparam logic [5:0] OP_LW    = 6'b010101;
  localparam logic [5:0] OP_SW    = 6'b010110;
  localparam logic [5:0] OP_BEQ   = 6'b010011;
  localparam logic [5:0] OP_JMP   = 6'b110000;

  // wait_cnt only has to reach TIMEOUT-1.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  instr_cnt;

  logic       pc_wrt, pc_wrt_cond;
  logic [1:0] pc_src;
  logic       i_or_d, mem_rd, mem_wrt, ir_wrt;
  logic       reg_dst, mem_to_reg, reg_wrt;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       trap;
  logic       waiting;     // state is blocked on mem_ready
  logic       timeout_hit; // this is the last permitted wait cycle
  logic       retire;

  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WAIT_W'(TIMEOUT - 1));

  // Next-state and output decode.
  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    pc_wrt      = 1'b0;
    pc_wrt_cond = 1'b0;
    pc_src      = 2'b00;
    i_or_d      = 1'b0;
    mem_rd      = 1'b0;
    mem_wrt     = 1'b0;
    ir_wrt      = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_wrt     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 3'b000;
    trap        = 1'b0;
    waiting     = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        // PC+4 is computed while the instruction is read; IR and PC load
        // only on the cycle the memory actually completes.
        mem_rd    = 1'b1;
        alu_src_b = 2'b01;
        ir_wrt    = bus.mem_ready;
        pc_wrt    = bus.mem_ready;
        waiting   = 1'b1;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11; // branch target precompute
        case (bus.opcode)
          OP_RTYPE, OP_SLT:                  state_d = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_XORI, OP_SLTI: state_d = S_EXEC_I;
          OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
          OP_BEQ:                            state_d = S_BRANCH;
          OP_JMP:                            state_d = S_JUMP;
          default:                           state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        i_or_d  = 1'b1;
        mem_rd  = 1'b1;
        waiting = 1'b1;
        if (bus.mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_wrt    = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        i_or_d  = 1'b1;
        mem_wrt = 1'b1;
        waiting = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_dst = 1'b1;
        reg_wrt = 1'b1;
        state_d = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (bus.opcode)
          OP_ANDI: alu_op = 3'b100;
          OP_XORI: alu_op = 3'b101;
          OP_SLTI: alu_op = 3'b110;
          default: alu_op = 3'b011;
        endcase
        state_d = S_I_WB;
      end
      S_I_WB: begin
        reg_wrt = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_op      = 3'b001;
        pc_wrt_cond = 1'b1;
        pc_src      = 2'b01;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_wrt  = 1'b1;
        pc_src  = 2'b10;
        state_d = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: state_d = S_TRAP; // unused encodings are treated as a fault
    endcase

    // mem_ready on the last permitted cycle still wins over the timeout.
    if (waiting && !bus.mem_ready && timeout_hit) state_d = S_TRAP;
  end

  // An instruction retires when it hands control back to FETCH.
  assign retire = (state_d == S_FETCH) &&
                  (state_q inside {S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB, S_BRANCH, S_JUMP});

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wait_cnt  <= '0;
      instr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        wait_cnt <= '0;
      else if (waiting && !bus.mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
      if (retire)
        instr_cnt <= instr_cnt + 1'b1;
    end
  end

  assign bus.pc_en      = pc_wrt | (pc_wrt_cond & bus.alu_zero);
  assign bus.pc_src     = pc_src;
  assign bus.i_or_d     = i_or_d;
  assign bus.mem_rd     = mem_rd;
  assign bus.mem_wrt    = mem_wrt;
  assign bus.ir_wrt     = ir_wrt;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.reg_wrt    = reg_wrt;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.trap       = trap;
  assign bus.state      = state_q;
  assign bus.instr_cnt  = instr_cnt;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_ctrl
// Builds a per-cycle plan of instructions (opcode, wait states, branch flag)
// from the instruction-level rules: phase lists per instruction class, a wait
// phase lasting waits+1 cycles unless TIMEOUT unready cycles elapse first,
// and a retired count that grows by one per completed instruction. A single
// negedge process compares the DUT against the plan entry applied that cycle.
// ---------------------------------------------------------------------------
module tb_multi_cycle_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEM_ADDR = 3,
                 ST_MEM_RD = 4, ST_MEM_WB = 5, ST_MEM_WR = 6, ST_EXEC_R = 7,
                 ST_R_WB = 8, ST_EXEC_I = 9, ST_I_WB = 10, ST_BRANCH = 11,
                 ST_JUMP = 12, ST_TRAP = 13;

  typedef enum int {K_R, K_I, K_LW, K_SW, K_BEQ, K_JMP, K_ILL} kind_t;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_rd;
    logic       mem_wrt;
    logic       ir_wrt;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_wrt;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       trap;
  } ctrl_t;

  typedef struct {
    int         st;
    logic [5:0] op;
    logic       rdy;
    logic       zero;
    int         cnt;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  multi_cycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

  multi_cycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_pass   = 0;
  int     retired  = 0;
  entry_t plan[$];
  entry_t cur_exp;
  bit     cur_valid = 1'b0;

  logic [5:0] legal_ops [11] = '{6'b000000, 6'b010111, 6'b010000, 6'b010001,
                                 6'b010010, 6'b011000, 6'b010101, 6'b010110,
                                 6'b010011, 6'b110000, 6'b010000};

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic kind_t classify(logic [5:0] op);
    case (op)
      6'b000000, 6'b010111:                     return K_R;
      6'b010000, 6'b010001, 6'b010010, 6'b011000: return K_I;
      6'b010101:                                return K_LW;
      6'b010110:                                return K_SW;
      6'b010011:                                return K_BEQ;
      6'b110000:                                return K_JMP;
      default:                                  return K_ILL;
    endcase
  endfunction

  // Control word each phase presents to the datapath.
  function automatic ctrl_t exp_ctrl(int st, logic [5:0] op, logic rdy, logic zero);
    ctrl_t c = '0;
    case (st)
      ST_FETCH:    begin c.mem_rd = 1; c.alu_src_b = 2'b01; c.ir_wrt = rdy; c.pc_en = rdy; end
      ST_DECODE:   c.alu_src_b = 2'b11;
      ST_MEM_ADDR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      ST_MEM_RD:   begin c.i_or_d = 1; c.mem_rd = 1; end
      ST_MEM_WB:   begin c.mem_to_reg = 1; c.reg_wrt = 1; end
      ST_MEM_WR:   begin c.i_or_d = 1; c.mem_wrt = 1; end
      ST_EXEC_R:   begin c.alu_src_a = 1; c.alu_op = 3'b010; end
      ST_R_WB:     begin c.reg_dst = 1; c.reg_wrt = 1; end
      ST_EXEC_I: begin
        c.alu_src_a = 1; c.alu_src_b = 2'b10;
        case (op)
          6'b010001: c.alu_op = 3'b100;
          6'b010010: c.alu_op = 3'b101;
          6'b011000: c.alu_op = 3'b110;
          default:   c.alu_op = 3'b011;
        endcase
      end
      ST_I_WB:     c.reg_wrt = 1;
      ST_BRANCH:   begin c.alu_src_a = 1; c.alu_op = 3'b001; c.pc_src = 2'b01; c.pc_en = zero; end
      ST_JUMP:     begin c.pc_en = 1; c.pc_src = 2'b10; end
      ST_TRAP:     c.trap = 1;
      default:     c = '0;
    endcase
    return c;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(int st, logic [5:0] op, logic rdy, logic zero);
    entry_t e;
    e.st = st; e.op = op; e.rdy = rdy; e.zero = zero;
    e.cnt = retired % (1 << CNT_W);
    plan.push_back(e);
  endfunction

  // A wait phase completes on its (waits+1)-th cycle, unless TIMEOUT
  // unready cycles come first; returns 1 when the phase ends in a trap.
  function automatic bit plan_wait(int st, logic [5:0] op, int waits);
    for (int i = 0; i <= waits; i++) begin
      if (TIMEOUT != 0 && i == TIMEOUT) return 1'b1;
      push(st, op, (i == waits), rb());
    end
    return 1'b0;
  endfunction

  function automatic bit plan_instr(logic [5:0] op, int wf, int wm, logic bz);
    kind_t k = classify(op);
    if (plan_wait(ST_FETCH, op, wf)) return 1'b1;
    push(ST_DECODE, op, rb(), rb());
    case (k)
      K_R:   begin push(ST_EXEC_R, op, rb(), rb()); push(ST_R_WB, op, rb(), rb()); end
      K_I:   begin push(ST_EXEC_I, op, rb(), rb()); push(ST_I_WB, op, rb(), rb()); end
      K_LW: begin
        push(ST_MEM_ADDR, op, rb(), rb());
        if (plan_wait(ST_MEM_RD, op, wm)) return 1'b1;
        push(ST_MEM_WB, op, rb(), rb());
      end
      K_SW: begin
        push(ST_MEM_ADDR, op, rb(), rb());
        if (plan_wait(ST_MEM_WR, op, wm)) return 1'b1;
      end
      K_BEQ: push(ST_BRANCH, op, rb(), bz);
      K_JMP: push(ST_JUMP, op, rb(), rb());
      default: return 1'b1;
    endcase
    retired++;
    return 1'b0;
  endfunction

  function automatic void plan_trap(int n);
    for (int i = 0; i < n; i++) push(ST_TRAP, 6'($urandom), rb(), rb());
  endfunction

  task automatic reset_dut();
    rst = 1'b1;
    retired = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Applies one plan entry per cycle, just after the rising edge; the first
  // entry is applied immediately (caller sits just after an edge).
  task automatic drive_plan();
    bit first = 1'b1;
    while (plan.size() > 0) begin
      if (!first) begin @(posedge clk); #1; end
      first = 1'b0;
      cur_exp = plan.pop_front();
      bus.opcode    = cur_exp.op;
      bus.mem_ready = cur_exp.rdy;
      bus.alu_zero  = cur_exp.zero;
      cur_valid     = 1'b1;
    end
    @(negedge clk);
    #1 cur_valid = 1'b0;
  endtask

  task automatic pin(string name, logic [5:0] op, int wf, int wm, int exp_len, int exp_trap);
    bit t;
    plan.delete();
    t = plan_instr(op, wf, wm, 1'b0);
    check({name, " len"}, plan.size(), exp_len);
    check({name, " trap"}, 32'(t), exp_trap);
    plan.delete();
    retired = 0;
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] op;
    if ($urandom_range(0, 39) != 0) return legal_ops[$urandom_range(0, 10)];
    do op = 6'($urandom); while (classify(op) != K_ILL);
    return op;
  endfunction

  function automatic int pick_wait();
    int r = $urandom_range(0, 39);
    if (r < 26) return 0;
    if (r < 38) return $urandom_range(1, 3);
    return $urandom_range(4, 5);
  endfunction

  // Single compare process.
  always @(negedge clk) begin
    if (cur_valid) begin
      ctrl_t act;
      act = {bus.pc_en, bus.pc_src, bus.i_or_d, bus.mem_rd, bus.mem_wrt, bus.ir_wrt,
             bus.reg_dst, bus.mem_to_reg, bus.reg_wrt, bus.alu_src_a, bus.alu_src_b,
             bus.alu_op, bus.trap};
      check("state", 32'(bus.state), cur_exp.st);
      check($sformatf("ctrl st=%0d op=%b", cur_exp.st, cur_exp.op), 32'(act),
            32'(exp_ctrl(cur_exp.st, cur_exp.op, cur_exp.rdy, cur_exp.zero)));
      check("instr_cnt", 32'(bus.instr_cnt), cur_exp.cnt);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    bit t;
    bus.opcode = '0; bus.mem_ready = 1'b0; bus.alu_zero = 1'b0;

    // Hand-computed latencies pin the model.
    pin("rtype",          6'b000000, 0, 0, 4, 0);
    pin("addi",           6'b010000, 0, 0, 4, 0);
    pin("sw",             6'b010110, 0, 0, 4, 0);
    pin("lw",             6'b010101, 0, 0, 5, 0);
    pin("lw 2 waits",     6'b010101, 0, 2, 7, 0);
    pin("beq",            6'b010011, 0, 0, 3, 0);
    pin("jmp",            6'b110000, 0, 0, 3, 0);
    pin("illegal",        6'b111111, 0, 0, 2, 1);
    pin("fetch timeout",  6'b000000, 4, 0, 4, 1);
    pin("ready 4th wait", 6'b000000, 3, 0, 7, 0);

    // Asynchronous reset in the middle of EXEC_R.
    reset_dut();
    push(ST_IDLE, 6'b000000, 1'b1, 1'b0);
    t = plan_instr(6'b000000, 0, 0, 1'b0);
    push(ST_FETCH, 6'b000000, 1'b1, 1'b0);
    push(ST_DECODE, 6'b000000, 1'b1, 1'b0);
    drive_plan();
    @(posedge clk);
    #2 check("pre-reset state", 32'(bus.state), 7);
    check("pre-reset instr_cnt", 32'(bus.instr_cnt), 1);
    bus.mem_ready = 1'b1;
    rst = 1'b1;
    #1 check("async reset state", 32'(bus.state), 0);
    check("async reset outputs", 32'({bus.pc_en, bus.pc_src, bus.i_or_d, bus.mem_rd,
          bus.mem_wrt, bus.ir_wrt, bus.reg_dst, bus.mem_to_reg, bus.reg_wrt,
          bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.trap}), 0);
    check("async reset instr_cnt", 32'(bus.instr_cnt), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("idle after release", 32'(bus.state), 0);
    @(posedge clk);
    #1 check("fetch after release", 32'(bus.state), 1);
    check("instr_cnt after release", 32'(bus.instr_cnt), 0);

    // R-type, lw with two wait states, beq taken and not taken.
    reset_dut();
    push(ST_IDLE, 6'b000000, 1'b0, 1'b0);
    t = plan_instr(6'b000000, 0, 0, 1'b0);
    t = plan_instr(6'b010101, 0, 2, 1'b0);
    t = plan_instr(6'b010011, 0, 0, 1'b1);
    t = plan_instr(6'b010011, 0, 0, 1'b0);
    drive_plan();
    @(posedge clk);
    #1 check("cnt after 4 instr", 32'(bus.instr_cnt), 4);

    // Illegal opcode after one retired instruction: trap held, count frozen.
    reset_dut();
    push(ST_IDLE, 6'b000000, 1'b0, 1'b0);
    t = plan_instr(6'b110000, 0, 0, 1'b0);
    t = plan_instr(6'b111111, 0, 0, 1'b0);
    plan_trap(20);
    drive_plan();
    check("trap flag held", 32'(bus.trap), 1);
    check("trap instr_cnt", 32'(bus.instr_cnt), 1);

    // Ready on the 4th waiting cycle, then a full timeout.
    reset_dut();
    push(ST_IDLE, 6'b000000, 1'b0, 1'b0);
    t = plan_instr(6'b000000, 3, 0, 1'b0);
    t = plan_instr(6'b010110, 0, 4, 1'b0);
    plan_trap(5);
    drive_plan();
    check("timeout state", 32'(bus.state), 13);

    // Randomized instruction streams, each starting from reset.
    for (int seg = 0; seg < 40; seg++) begin
      int n;
      reset_dut();
      push(ST_IDLE, 6'($urandom), rb(), rb());
      n = $urandom_range(5, 24);
      for (int i = 0; i < n; i++) begin
        if (plan_instr(pick_op(), pick_wait(), pick_wait(), rb())) begin
          plan_trap(6);
          break;
        end
      end
      drive_plan();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
